// File: rtl/mp_mem_pkg.sv
// mp_mem_pkg: default sizes and the port-index type shared by the shared-memory block
package mp_mem_pkg;
   localparam int NUM_PORTS_DEF  = 4;
   localparam int ADDR_WIDTH_DEF = 11;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int MAX_PORTS      = 8;
   typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
endpackage

// File: rtl/mp_rr_arbiter.sv
// mp_rr_arbiter: round-robin grant over N requests, pointer advances past each granted port
//   in : clk, reset_n (async active-low), req[N], advance (a transfer happens this cycle)
//   out: gnt[N] one-hot or zero, gnt_idx index of the granted port
module mp_rr_arbiter
   import mp_mem_pkg::*;
#(
   parameter int N = NUM_PORTS_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt,
   output port_idx_t    gnt_idx
);
   localparam int PW = $clog2(N);
   logic [PW-1:0]  r_ptr;
   logic [2*N-1:0] w_dbl;
   logic [PW:0]    w_sum;
   logic           w_found;
   // Rotating a doubled copy of req puts the search start at bit 0;
   // the offset of the first hit plus ptr, wrapped once, is the winner.
   always_comb begin
      w_dbl   = {req, req} >> r_ptr;
      w_found = 1'b0;
      w_sum   = '0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && w_dbl[i]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_ptr} + (PW+1)'(i);
         end
      end
      gnt_idx = port_idx_t'(w_sum >= (PW+1)'(N) ? w_sum - (PW+1)'(N) : w_sum);
      gnt     = '0;
      for (int p = 0; p < N; p++) gnt[p] = w_found && reset_n && gnt_idx == port_idx_t'(p);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ptr <= '0;
      else if (advance) r_ptr <= gnt_idx == port_idx_t'(N-1) ? '0 : PW'(gnt_idx + 1'b1);
   end
endmodule

// File: rtl/mp_shared_mem.sv
// mp_shared_mem: single-bank memory shared by NUM_PORTS ports, one round-robin access per cycle
//   in : clk, reset_n (async active-low), per-port addr/data_in/we/read_en (packed slices)
//   out: gnt (combinational grant), per-port data_out (registered) and one-cycle valid_out
module mp_shared_mem
   import mp_mem_pkg::*;
#(
   parameter int NUM_PORTS  = NUM_PORTS_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_PORTS-1:0]            we,
   input  logic [NUM_PORTS-1:0]            read_en,
   output logic [NUM_PORTS-1:0]            gnt,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
   output logic [NUM_PORTS-1:0]            valid_out
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [NUM_PORTS-1:0]  w_req, w_rd_gnt;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_din;
   logic                  w_xfer, w_wr;
   port_idx_t             w_idx, r_rsp_idx;
   logic                  r_rsp_rd;
   assign w_req    = we | read_en;
   assign w_xfer   = |gnt;
   assign w_wr     = |(gnt & we);
   // A write wins when both we and read_en are set, so it never produces a response.
   assign w_rd_gnt = gnt & read_en & ~we;
   mp_rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (w_req),
      .advance (w_xfer),
      .gnt     (gnt),
      .gnt_idx (w_idx)
   );
   always_comb begin
      w_addr = '0;
      w_din  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt[p]) begin
            w_addr = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            w_din  = data_in[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[w_addr] <= w_din;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_rd  <= 1'b0;
         r_rsp_idx <= '0;
         data_out  <= '0;
      end else begin
         r_rsp_rd  <= |w_rd_gnt;
         r_rsp_idx <= w_idx;
         for (int p = 0; p < NUM_PORTS; p++)
            if (w_rd_gnt[p]) data_out[p*DATA_WIDTH +: DATA_WIDTH] <= r_mem[w_addr];
      end
   end
   always_comb begin
      valid_out = '0;
      for (int p = 0; p < NUM_PORTS; p++) valid_out[p] = r_rsp_rd && r_rsp_idx == port_idx_t'(p);
   end
endmodule

// File: doc/mp_shared_mem.md
Name: mp_shared_mem

Overview:
- Shared single-bank memory serving NUM_PORTS processor ports: each port has its own addr/data_in/we/read_en request and its own data_out/valid_out response.
- A round-robin arbiter grants one access per cycle.
- Generalises the single-port memory DUT (11-bit addr, 8-bit data, we/read_en/valid_out) to N ports, adding arbitration, backpressure (gnt) and per-port response routing.
- Sits between the processor cores and the common memory in the multiprocessor system.

Parameters:
- NUM_PORTS, 4, number of requesting ports (2..8).
- ADDR_WIDTH, 11, word address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width.

Ports:
- clk  input  1  single clock, all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- addr  input  NUM_PORTS*ADDR_WIDTH  per-port address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- data_in  input  NUM_PORTS*DATA_WIDTH  per-port write data, sliced the same way.
- we  input  NUM_PORTS  per-port write request.
- read_en  input  NUM_PORTS  per-port read request.
- gnt  output  NUM_PORTS  one-hot (or zero) grant; combinational from requests and the priority pointer.
- data_out  output  NUM_PORTS*DATA_WIDTH  per-port read data, registered.
- valid_out  output  NUM_PORTS  per-port one-cycle read-data-valid pulse.

Behaviour:
- Request definition: req[p] = we[p] | read_en[p].
  - If both we[p] and read_en[p] are set, the access is a write only, and no valid_out is produced.
- Arbitration: round-robin over req.
  - Search starts at pointer ptr and wraps modulo NUM_PORTS.
  - gnt[p] = 1 for the first requesting port found; at most one bit of gnt is set; gnt = 0 when req = 0.
- Transfer: occurs at the posedge where gnt[p] = 1.
  - Requestor holds addr/data_in/we/read_en stable until it sees gnt[p].
  - Deasserting a request before grant withdraws it with no side effects.
- Pointer update: on a transfer, ptr <= (granted index + 1) mod NUM_PORTS. With no transfer, ptr holds.
- Write: on a transfer with we[p], mem[addr_p] <= data_in_p. There is no response.
- Read latency is 1 cycle:
  - Read granted in cycle N → valid_out[p] = 1 and data_out slice p = mem[addr_p] in cycle N+1.
  - valid_out[p] is 0 in all other cycles.
  - data_out slice p holds its last read value until that port's next read.
- At most one port can have valid_out set per cycle.
- Back-to-back: a port may be re-granted in consecutive cycles only if no other port is requesting.
- Same-address write then read from different ports in consecutive cycles: the read returns the new data. Only one access occurs per cycle, so there is no same-cycle hazard.
- Fairness: with all ports continuously requesting, each port is granted exactly once every NUM_PORTS cycles.
- Reset (async assert, synchronous-to-clk deassert by the system):
  - ptr = 0, valid_out = 0, data_out = 0.
  - gnt is forced to 0 while reset_n = 0.
  - Memory contents are not cleared and are undefined after power-up.
  - Reset mid-operation: an in-flight read response scheduled for the next cycle is dropped (valid_out stays 0).
- Width rules:
  - The address indexes the full DEPTH with no out-of-range case.
  - The pointer is $clog2(NUM_PORTS) bits, with explicit wrap when NUM_PORTS is not a power of two.

Decomposition:
- Package mp_mem_pkg: default ADDR_WIDTH/DATA_WIDTH/NUM_PORTS constants, and a port-index typedef sized $clog2 of the max port count (8).
- Sub-module mp_rr_arbiter (parameter N):
  - Inputs: clk, reset_n, req[N], advance.
  - Outputs: gnt[N] one-hot, gnt_idx.
  - Owns ptr.
- The top level holds the memory array, the response register (registered port index + read flag) and the slice muxing.

Test Plan:
- Reset values: assert reset_n = 0 with random inputs → gnt = 0, valid_out = 0, data_out = 0. Release, idle → all remain 0.
- Single port write/read: port 2 writes 0xA5 to addr 0x3FF, then reads 0x3FF → gnt[2] immediately each time; valid_out[2] pulses one cycle after the read grant with data 0xA5; other ports see no valid_out.
- Round-robin: all 4 ports hold read_en from reset → grants are 0,1,2,3,0,1… with exactly one gnt bit per cycle. Each valid_out[p] follows its grant by 1 cycle.
- Pointer resume: only ports 1 and 3 request; after port 3 is granted, port 0 requests → next grant order is 0, then 1, then 3.
- Cross-port coherency and the both-set case:
  - Port 0 writes 0x5A to addr 0x010; port 1 reads addr 0x010 next cycle → port 1 gets 0x5A.
  - Port 0 with we = read_en = 1 → write happens, no valid_out[0].
- Reset mid-read: read granted, then reset_n = 0 before the next posedge → valid_out stays 0. After release, ptr = 0 and a subsequent read of the previously written address returns the stored data.
